trace_retire_buffer: RTL and testbench

//  Synthesizable successor to the bench-only retire tracer. Sits beside proc core,

---
 rtl/trace_retire_buffer_pkg.sv | 50 +++++
 rtl/trace_retire_buffer_if.sv | 36 +++
 rtl/trace_retire_buffer_fifo.sv | 48 ++++
 rtl/trace_retire_buffer.sv | 118 +++++++++++
 tb/tb_trace_retire_buffer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/trace_retire_buffer_pkg.sv
// Shared types for the retire trace buffer: event kinds, FSM states, trace record layout.
package trace_retire_buffer_pkg;

    localparam int unsigned PC_W   = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned INUM_W = 32;

    typedef enum logic [2:0] {
        KIND_REG   = 3'd0,
        KIND_LD    = 3'd1,
        KIND_STU   = 3'd2,
        KIND_ST    = 3'd3,
        KIND_OTHER = 3'd4,
        KIND_HALT  = 3'd5
    } kind_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Field order fixes the record bit layout, inum in the MSBs.
    typedef struct packed {
        logic [INUM_W-1:0] inum;
        kind_e             kind;
        logic [PC_W-1:0]   pc;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] reg_data;
        logic [DATA_W-1:0] mem_addr;
        logic [DATA_W-1:0] mem_data;
    } trace_rec_t;

    localparam int unsigned REC_W = $bits(trace_rec_t);

    // First matching rule wins; a register write outranks halt.
    function automatic kind_e classify(input logic reg_wr, input logic mem_rd,
                                       input logic mem_wr, input logic halt);
        kind_e k;
        if (reg_wr && mem_wr)      k = KIND_STU;
        else if (reg_wr && mem_rd) k = KIND_LD;
        else if (reg_wr)           k = KIND_REG;
        else if (halt)             k = KIND_HALT;
        else if (mem_wr)           k = KIND_ST;
        else                       k = KIND_OTHER;
        return k;
    endfunction

endpackage

// File: rtl/trace_retire_buffer_if.sv
// Retire-event input and trace-record output channels of the retire trace buffer.
interface trace_retire_buffer_if;
    import trace_retire_buffer_pkg::*;

    logic              ret_valid;
    logic [PC_W-1:0]   ret_pc;
    logic              ret_reg_wr;
    logic [REG_AW-1:0] ret_reg;
    logic [DATA_W-1:0] ret_reg_data;
    logic              ret_mem_rd;
    logic              ret_mem_wr;
    logic [DATA_W-1:0] ret_mem_addr;
    logic [DATA_W-1:0] ret_mem_data;
    logic              ret_halt;
    logic              ret_stall;

    logic              tr_valid;
    logic              tr_ready;
    trace_rec_t        tr_data;

    // Core plus trace consumer side
    modport master (
        output ret_valid, ret_pc, ret_reg_wr, ret_reg, ret_reg_data,
               ret_mem_rd, ret_mem_wr, ret_mem_addr, ret_mem_data, ret_halt,
               tr_ready,
        input  ret_stall, tr_valid, tr_data
    );

    // Trace buffer side
    modport slave (
        input  ret_valid, ret_pc, ret_reg_wr, ret_reg, ret_reg_data,
               ret_mem_rd, ret_mem_wr, ret_mem_addr, ret_mem_data, ret_halt,
               tr_ready,
        output ret_stall, tr_valid, tr_data
    );
endinterface

// File: rtl/trace_retire_buffer_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module trace_retire_buffer_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata_c,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != CW'(0));
    assign w_push = i_push && (r_count != CW'(DEPTH));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    // Storage needs no reset; occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata_c = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/trace_retire_buffer.sv
// Retire trace buffer: classifies retire events, numbers them, queues them and
// streams trace records; tracks instruction/cycle/drop counts and halt drain.
module trace_retire_buffer
    import trace_retire_buffer_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter bit          DROP_ON_FULL = 1'b0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    trace_retire_buffer_if.slave bus,
    output logic [INUM_W-1:0]   o_inst_count,
    output logic [INUM_W-1:0]   o_cycle_count,
    output logic [INUM_W-1:0]   o_drop_count,
    output logic                o_overflow,
    output logic                o_done
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [INUM_W-1:0] r_inst_count;
    logic [INUM_W-1:0] r_cycle_count;
    logic [INUM_W-1:0] r_drop_count;
    logic              r_overflow;
    logic              r_done;

    logic [CW-1:0]     w_count;
    logic [REC_W-1:0]  w_rdata;
    kind_e             w_kind;
    logic              w_is_halt;
    logic              w_take;
    logic              w_elig;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    trace_rec_t        w_rec;

    assign w_kind    = classify(bus.ret_reg_wr, bus.ret_mem_rd, bus.ret_mem_wr, bus.ret_halt);
    assign w_is_halt = (w_kind == KIND_HALT);
    assign w_take    = bus.ret_valid && (r_state == ST_RUN);

    // Last slot is held back for the halt record so the stream always ends with it.
    assign w_elig = w_is_halt ? (w_count < CW'(DEPTH)) : (w_count < CW'(DEPTH - 1));
    assign w_push = w_take && w_elig;
    assign w_drop = w_take && !w_elig && !w_is_halt && DROP_ON_FULL;
    assign w_pop  = bus.tr_valid && bus.tr_ready;

    always_comb begin
        w_rec          = '0;
        w_rec.inum     = r_inst_count;
        w_rec.kind     = w_kind;
        w_rec.pc       = bus.ret_pc;
        w_rec.rd       = bus.ret_reg;
        w_rec.reg_data = bus.ret_reg_data;
        w_rec.mem_addr = bus.ret_mem_addr;
        w_rec.mem_data = bus.ret_mem_data;
    end

    trace_retire_buffer_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (w_push),
        .i_wdata   (w_rec),
        .i_pop     (w_pop),
        .o_rdata_c (w_rdata),
        .o_count   (w_count)
    );

    assign bus.tr_valid  = (w_count != CW'(0));
    assign bus.tr_data   = trace_rec_t'(w_rdata);
    assign bus.ret_stall = !DROP_ON_FULL && (r_state == ST_RUN) && (w_count >= CW'(DEPTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    // DONE is entered on the edge that pops the last record while draining.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (w_push && w_is_halt) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if ((w_count == CW'(0)) || ((w_count == CW'(1)) && w_pop))
                          w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inst_count  <= INUM_W'(0);
            r_cycle_count <= INUM_W'(0);
            r_drop_count  <= INUM_W'(0);
            r_overflow    <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            if (w_push || w_drop)   r_inst_count  <= r_inst_count + INUM_W'(1);
            if (r_state != ST_DONE) r_cycle_count <= r_cycle_count + INUM_W'(1);
            if (w_drop) begin
                r_drop_count <= r_drop_count + INUM_W'(1);
                r_overflow   <= 1'b1;
            end
            r_done <= (w_state_nxt == ST_DONE);
        end
    end

    assign o_inst_count  = r_inst_count;
    assign o_cycle_count = r_cycle_count;
    assign o_drop_count  = r_drop_count;
    assign o_overflow    = r_overflow;
    assign o_done        = r_done;

endmodule

// File: tb/tb_trace_retire_buffer.sv
// Randomized bench: a stall-mode and a drop-mode buffer (DEPTH=4) share one stimulus
// stream and are each compared every cycle against a list-based reference model.
module tb_trace_retire_buffer;
    import trace_retire_buffer_pkg::*;

    localparam int D     = 4;
    localparam int M_RUN = 0;
    localparam int M_DRN = 1;
    localparam int M_DON = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              s_valid = 1'b0, s_reg_wr = 1'b0, s_mem_rd = 1'b0, s_mem_wr = 1'b0;
    logic              s_halt = 1'b0, s_ready = 1'b0;
    logic [PC_W-1:0]   s_pc = '0;
    logic [REG_AW-1:0] s_reg = '0;
    logic [DATA_W-1:0] s_rdata = '0, s_addr = '0, s_mdata = '0;

    trace_retire_buffer_if bus0 ();
    trace_retire_buffer_if bus1 ();

    assign bus0.ret_valid = s_valid;     assign bus1.ret_valid = s_valid;
    assign bus0.ret_pc = s_pc;           assign bus1.ret_pc = s_pc;
    assign bus0.ret_reg_wr = s_reg_wr;   assign bus1.ret_reg_wr = s_reg_wr;
    assign bus0.ret_reg = s_reg;         assign bus1.ret_reg = s_reg;
    assign bus0.ret_reg_data = s_rdata;  assign bus1.ret_reg_data = s_rdata;
    assign bus0.ret_mem_rd = s_mem_rd;   assign bus1.ret_mem_rd = s_mem_rd;
    assign bus0.ret_mem_wr = s_mem_wr;   assign bus1.ret_mem_wr = s_mem_wr;
    assign bus0.ret_mem_addr = s_addr;   assign bus1.ret_mem_addr = s_addr;
    assign bus0.ret_mem_data = s_mdata;  assign bus1.ret_mem_data = s_mdata;
    assign bus0.ret_halt = s_halt;       assign bus1.ret_halt = s_halt;
    assign bus0.tr_ready = s_ready;      assign bus1.tr_ready = s_ready;

    logic [INUM_W-1:0] inst0, cyc0, drop0, inst1, cyc1, drop1;
    logic              ovf0, done0, ovf1, done1;

    trace_retire_buffer #(.DEPTH(D), .DROP_ON_FULL(1'b0)) u_stall (
        .i_clk(clk), .i_rst(rst), .bus(bus0.slave),
        .o_inst_count(inst0), .o_cycle_count(cyc0), .o_drop_count(drop0),
        .o_overflow(ovf0), .o_done(done0)
    );

    trace_retire_buffer #(.DEPTH(D), .DROP_ON_FULL(1'b1)) u_drop (
        .i_clk(clk), .i_rst(rst), .bus(bus1.slave),
        .o_inst_count(inst1), .o_cycle_count(cyc1), .o_drop_count(drop1),
        .o_overflow(ovf1), .o_done(done1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [REC_W-1:0]  mq   [2][16];
    int                msz  [2] = '{0, 0};
    int                mst  [2] = '{M_RUN, M_RUN};
    logic [INUM_W-1:0] minst[2] = '{'0, '0};
    logic [INUM_W-1:0] mcyc [2] = '{'0, '0};
    logic [INUM_W-1:0] mdrop[2] = '{'0, '0};
    logic              movf [2] = '{1'b0, 1'b0};
    bit                mmode[2] = '{1'b0, 1'b1};

    function automatic logic [2:0] ref_kind(input logic rw, input logic mr, input logic mw, input logic h);
        if (rw && mw) return 3'd2;
        if (rw && mr) return 3'd1;
        if (rw)       return 3'd0;
        if (h)        return 3'd5;
        if (mw)       return 3'd3;
        return 3'd4;
    endfunction

    always @(posedge clk) begin
        int       pre, pst;
        logic [2:0] kind;
        bit       halt, ok;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                msz[k] = 0; mst[k] = M_RUN; minst[k] = '0; mcyc[k] = '0;
                mdrop[k] = '0; movf[k] = 1'b0;
            end else begin
                pre = msz[k];
                pst = mst[k];
                if (pst != M_DON) mcyc[k] = mcyc[k] + 1;
                if (pre > 0 && s_ready) begin
                    for (int j = 0; j < 15; j++) mq[k][j] = mq[k][j+1];
                    msz[k] = msz[k] - 1;
                end
                if (pst == M_RUN && s_valid) begin
                    kind = ref_kind(s_reg_wr, s_mem_rd, s_mem_wr, s_halt);
                    halt = (kind == 3'd5);
                    ok   = halt ? (pre < D) : (pre < D - 1);
                    if (ok) begin
                        mq[k][msz[k]] = {minst[k], kind, s_pc, s_reg, s_rdata, s_addr, s_mdata};
                        msz[k]   = msz[k] + 1;
                        minst[k] = minst[k] + 1;
                        if (halt) mst[k] = M_DRN;
                    end else if (mmode[k]) begin
                        minst[k] = minst[k] + 1;
                        mdrop[k] = mdrop[k] + 1;
                        movf[k]  = 1'b1;
                    end
                end
                if (pst == M_DRN && msz[k] == 0) mst[k] = M_DON;
            end
        end
    end

    task automatic check_inst(input int k, input logic v, input trace_rec_t d, input logic stall,
                              input logic [INUM_W-1:0] ic, input logic [INUM_W-1:0] cc,
                              input logic [INUM_W-1:0] dc, input logic ov, input logic dn);
        check($sformatf("tr_valid%0d", k), 128'(v), 128'(msz[k] > 0));
        if (msz[k] > 0) check($sformatf("tr_data%0d", k), 128'(d), 128'(mq[k][0]));
        check($sformatf("ret_stall%0d", k), 128'(stall),
              128'(!mmode[k] && mst[k] == M_RUN && msz[k] >= D - 1));
        check($sformatf("inst_count%0d", k), 128'(ic), 128'(minst[k]));
        check($sformatf("cycle_count%0d", k), 128'(cc), 128'(mcyc[k]));
        check($sformatf("drop_count%0d", k), 128'(dc), 128'(mdrop[k]));
        check($sformatf("overflow%0d", k), 128'(ov), 128'(movf[k]));
        check($sformatf("done%0d", k), 128'(dn), 128'(mst[k] == M_DON));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_inst(0, bus0.tr_valid, bus0.tr_data, bus0.ret_stall, inst0, cyc0, drop0, ovf0, done0);
            check_inst(1, bus1.tr_valid, bus1.tr_data, bus1.ret_stall, inst1, cyc1, drop1, ovf1, done1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic rand_event();
        s_valid  = ($urandom_range(0, 99) < 70);
        s_pc     = PC_W'($urandom);
        s_reg_wr = 1'($urandom);
        s_reg    = REG_AW'($urandom);
        s_rdata  = DATA_W'($urandom);
        s_mem_rd = 1'($urandom);
        s_mem_wr = 1'($urandom);
        s_addr   = DATA_W'($urandom);
        s_mdata  = DATA_W'($urandom);
        s_halt   = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        int  ready_pct, halt_at, rst_at;
        bit  finished;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single REG retire into an empty buffer shows up one cycle later.
        s_valid = 1'b1; s_pc = 16'h0002; s_reg_wr = 1'b1; s_reg = 3'd3; s_rdata = 16'h1234;
        @(negedge clk);
        s_valid = 1'b0; s_reg_wr = 1'b0;
        check("first_valid", 128'(bus0.tr_valid), 128'(1));
        check("first_inum", 128'(bus0.tr_data.inum), 128'(0));
        check("first_kind", 128'(bus0.tr_data.kind), 128'(0));
        check("first_reg", 128'(bus0.tr_data.rd), 128'(3));
        check("first_pc", 128'(bus0.tr_data.pc), 128'(16'h0002));
        repeat (2) @(negedge clk);

        for (int ep = 0; ep < 40; ep++) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            ready_pct = (ep % 3 == 0) ? 10 : int'($urandom_range(20, 95));
            halt_at   = int'($urandom_range(4, 50));
            rst_at    = (ep % 4 == 3) ? halt_at + int'($urandom_range(1, 4)) : -1;
            finished  = 1'b0;
            for (int c = 0; c < 400 && !finished; c++) begin
                if (!(s_valid && bus0.ret_stall && !s_halt)) rand_event();
                if (c == halt_at) begin
                    s_valid = 1'b1; s_halt = 1'b1;
                    s_reg_wr = 1'b0; s_mem_rd = 1'b0; s_mem_wr = 1'b0;
                end
                s_ready = ($urandom_range(0, 99) < ready_pct);
                rst     = (c == rst_at);
                @(negedge clk);
                if (rst_at < 0 && c > halt_at + 8 && done0 && done1) finished = 1'b1;
                if (rst_at >= 0 && c > rst_at + 20) finished = 1'b1;
            end
            rst = 1'b0;
            if (rst_at < 0) check("drain_timeout", 128'(finished), 128'(1));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
